// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo front end: issue-class and operation enums,
// RV-style opcode/funct encodings and the decoded instruction-queue entry.
package tomasulo_pkg;

  typedef enum logic [1:0] {
    UNIT_LD     = 2'd0,
    UNIT_ALU    = 2'd1,
    UNIT_MULDIV = 2'd2
  } unit_e;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_DIV = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    DEC_OK,
    DEC_HALT,
    DEC_ILL
  } dec_kind_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_ALU    = 7'b0110011;
  localparam logic [6:0] OPC_MULDIV = 7'b1100011;
  localparam logic [6:0] OPC_HALT   = 7'b0010100;

  localparam logic [2:0] F3_LW     = 3'b010;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_DIV    = 3'b001;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    unit_e       unit;
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } iq_entry_t;

endpackage

// File: rtl/iq_fifo.sv
// Synchronous FIFO of decoded entries; head is the oldest entry, valid while
// count is non-zero. Callers never push when full or pop when empty.
module iq_fifo
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  iq_entry_t     din,
  output iq_entry_t     head,
  output logic [CW-1:0] count,
  output logic          empty
);

  iq_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // NOTE: storage is not reset; only pointers and count define which slots are live.
  always_ff @(posedge clk1) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/issue_unit.sv
// In-order fetch/decode/issue front end feeding the reservation stations.
// Optional build macro ISSUE_STALL_CNT_EN adds the saturating stall_cnt port.
module issue_unit
  import tomasulo_pkg::*;
#(
  parameter int IQ_DEPTH = 4,
  parameter int PC_W     = 7
) (
  input  logic            clk1,
  input  logic            rst,
  output logic [PC_W-1:0] pc_out,
  input  logic [31:0]     inst_in,
  input  logic [2:0]      rs_ready,
  output logic            iss_valid,
  output logic [1:0]      iss_unit,
  output logic [2:0]      iss_op,
  output logic [4:0]      iss_rd,
  output logic [4:0]      iss_rs1,
  output logic [4:0]      iss_rs2,
  output logic [11:0]     iss_imm,
  output logic            halted,
`ifdef ISSUE_STALL_CNT_EN
  output logic [15:0]     stall_cnt,
`endif
  output logic            illegal
);

  localparam int CW = $clog2(IQ_DEPTH) + 1;

  logic [PC_W-1:0] next_pc;
  logic            v_a, v_b, halt_seen, req;
  logic [CW+1:0]   credit;
  logic [CW-1:0]   count;
  logic            empty, capture, push, pop, unit_ready;
  iq_entry_t       dec, head, held, shown;
  dec_kind_e       dec_kind;

  // Entries already queued plus words still in the two-stage fetch pipe.
  assign credit = (CW+2)'(count) + (CW+2)'(v_a) + (CW+2)'(v_b);
  assign req    = !halt_seen && (credit < (CW+2)'(IQ_DEPTH));

  always_comb begin
    dec      = '0;
    dec_kind = DEC_ILL;
    case (inst_in[6:0])
      OPC_LOAD: if (inst_in[14:12] == F3_LW) begin
        dec.unit = UNIT_LD;
        dec.op   = OP_LW;
        dec.rd   = inst_in[11:7];
        dec.rs1  = inst_in[19:15];
        dec.imm  = inst_in[31:20];
        dec_kind = DEC_OK;
      end
      OPC_ALU: if (inst_in[14:12] == F3_ADDSUB &&
                   (inst_in[31:25] == F7_BASE || inst_in[31:25] == F7_SUB)) begin
        dec.unit = UNIT_ALU;
        dec.op   = (inst_in[31:25] == F7_SUB) ? OP_SUB : OP_ADD;
        dec.rd   = inst_in[11:7];
        dec.rs1  = inst_in[19:15];
        dec.rs2  = inst_in[24:20];
        dec_kind = DEC_OK;
      end
      OPC_MULDIV: if (inst_in[31:25] == F7_MULDIV &&
                      (inst_in[14:12] == F3_MUL || inst_in[14:12] == F3_DIV)) begin
        dec.unit = UNIT_MULDIV;
        dec.op   = (inst_in[14:12] == F3_DIV) ? OP_DIV : OP_MUL;
        dec.rd   = inst_in[11:7];
        dec.rs1  = inst_in[19:15];
        dec.rs2  = inst_in[24:20];
        dec_kind = DEC_OK;
      end
      OPC_HALT: dec_kind = DEC_HALT;
      default:  dec_kind = DEC_ILL;
    endcase
    if (inst_in == 32'd0) dec_kind = DEC_HALT;
  end

  // Words arriving after HALT was latched are stale and must be discarded.
  assign capture = v_b && !halt_seen;
  assign push    = capture && (dec_kind == DEC_OK);

  always_comb begin
    case (shown.unit)
      UNIT_LD:     unit_ready = rs_ready[0];
      UNIT_ALU:    unit_ready = rs_ready[1];
      UNIT_MULDIV: unit_ready = rs_ready[2];
      default:     unit_ready = 1'b0;
    endcase
  end

  assign pop = iss_valid && unit_ready;

  iq_fifo #(.DEPTH(IQ_DEPTH)) u_iq (
    .clk1  (clk1),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (dec),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      next_pc   <= '0;
      pc_out    <= '0;
      v_a       <= 1'b0;
      v_b       <= 1'b0;
      halt_seen <= 1'b0;
      illegal   <= 1'b0;
      held      <= '0;
    end else begin
      v_a <= req;
      if (req) begin
        pc_out  <= next_pc;
        next_pc <= next_pc + 1'b1;
      end
      v_b <= v_a && !halt_seen;
      if (capture && dec_kind == DEC_HALT) halt_seen <= 1'b1;
      if (capture && dec_kind == DEC_ILL)  illegal   <= 1'b1;
      if (!empty) held <= head;
    end
  end

  // Once the queue drains the outputs keep showing the last head.
  assign shown     = empty ? held : head;
  assign iss_valid = !empty;
  assign iss_unit  = shown.unit;
  assign iss_op    = shown.op;
  assign iss_rd    = shown.rd;
  assign iss_rs1   = shown.rs1;
  assign iss_rs2   = shown.rs2;
  assign iss_imm   = shown.imm;
  assign halted    = halt_seen && empty;

`ifdef ISSUE_STALL_CNT_EN
  always_ff @(posedge clk1) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (iss_valid && !unit_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_unit.sv
// Scoreboard bench for issue_unit: programs are loaded into a fetch model,
// expected decoded entries queued at load time and compared at each pop.
module tb_issue_unit;

  localparam int IQ_DEPTH = 4;
  localparam int PC_W     = 7;

  logic            clk1 = 1'b0;
  logic            rst  = 1'b1;
  logic [PC_W-1:0] pc_out;
  logic [31:0]     inst_in = '0;
  logic [2:0]      rs_ready = '0;
  logic            iss_valid, halted, illegal;
  logic [1:0]      iss_unit;
  logic [2:0]      iss_op;
  logic [4:0]      iss_rd, iss_rs1, iss_rs2;
  logic [11:0]     iss_imm;
`ifdef ISSUE_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  issue_unit #(.IQ_DEPTH(IQ_DEPTH), .PC_W(PC_W)) dut (
    .clk1      (clk1),
    .rst       (rst),
    .pc_out    (pc_out),
    .inst_in   (inst_in),
    .rs_ready  (rs_ready),
    .iss_valid (iss_valid),
    .iss_unit  (iss_unit),
    .iss_op    (iss_op),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_imm   (iss_imm),
    .halted    (halted),
`ifdef ISSUE_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .illegal   (illegal)
  );

  always #5 clk1 = ~clk1;

  logic [31:0] prog [2**PC_W];
  logic [31:0] sb [$];
  int n_checks = 0;
  int n_errors = 0;
  int n_issued = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic [1:0] u, input logic [2:0] o, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    return {u, o, rd, rs1, rs2, imm};
  endfunction

  function automatic logic [31:0] rr_word(input logic [2:0] o, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
    case (o)
      3'd1:    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3'd2:    return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3'd3:    return {7'b0000001, rs2, rs1, 3'b000, rd, 7'b1100011};
      default: return {7'b0000001, rs2, rs1, 3'b001, rd, 7'b1100011};
    endcase
  endfunction

  task automatic put_lw(input int pc, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    prog[pc] = {imm, rs1, 3'b010, rd, 7'b0000011};
    sb.push_back(ent(2'd0, 3'd0, rd, rs1, 5'd0, imm));
  endtask

  task automatic put_rr(input int pc, input logic [2:0] o, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    prog[pc] = rr_word(o, rd, rs1, rs2);
    sb.push_back(ent((o >= 3'd3) ? 2'd2 : 2'd1, o, rd, rs1, rs2, 12'd0));
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 2**PC_W; i++) prog[i] = '0;
    sb.delete();
    n_issued = 0;
  endtask

  task automatic prog1();
    put_lw(0, 5'd3, 5'd2, 12'd0);
    put_rr(1, 3'd4, 5'd2, 5'd3, 5'd4);
    put_rr(2, 3'd3, 5'd1, 5'd5, 5'd6);
    put_rr(3, 3'd1, 5'd3, 5'd7, 5'd8);
    put_rr(4, 3'd3, 5'd9, 5'd1, 5'd3);
    put_rr(5, 3'd2, 5'd4, 5'd9, 5'd5);
    put_rr(6, 3'd1, 5'd1, 5'd4, 5'd2);
  endtask

  task automatic reset_dut();
    @(posedge clk1); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk1);
    #1;
    check("rst_iss_valid", 32'(iss_valid), 32'd0);
    check("rst_pc_out", 32'(pc_out), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_iss_fields", {iss_unit, iss_op, iss_rd, iss_rs1, iss_rs2, iss_imm}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_halted(input string tag);
    int n = 0;
    while (!halted && n < 300) begin
      @(posedge clk1); #1;
      n++;
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  // Fetch model: word for the PC sampled at an edge is valid in the next cycle.
  always begin : fetch_model
    logic [PC_W-1:0] a;
    @(posedge clk1);
    a = pc_out;
    #1;
    inst_in = prog[a];
  end

  // A pop happens at the coming edge whenever the head's class is ready.
  always @(negedge clk1) begin
    if (!rst && iss_valid && iss_unit != 2'd3 && rs_ready[iss_unit]) begin
      check("issue_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0)
        check("issue_entry", {iss_unit, iss_op, iss_rd, iss_rs1, iss_rs2, iss_imm}, sb.pop_front());
      n_issued++;
    end
  end

  initial begin
    logic [PC_W-1:0] p;

    // 1: full program, all stations ready
    clear_prog();
    prog1();
    rs_ready = 3'b111;
    reset_dut();
    wait_halted("t1_halted");
    check("t1_issued", 32'(n_issued), 32'd7);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    check("t1_iss_valid", 32'(iss_valid), 32'd0);
    check("t1_hold_last", {iss_unit, iss_op, iss_rd, iss_rs1, iss_rs2, iss_imm},
          ent(2'd1, 3'd1, 5'd1, 5'd4, 5'd2, 12'd0));
    repeat (4) @(posedge clk1);
    #1;
    check("t1_halted_sticky", 32'(halted), 32'd1);

    // 2: no station ready, queue fills and fetch stalls
    clear_prog();
    prog1();
    rs_ready = 3'b000;
    reset_dut();
    repeat (12) @(posedge clk1);
    #1;
    p = pc_out;
    check("t2_iss_valid", 32'(iss_valid), 32'd1);
    check("t2_head_lw", {iss_unit, iss_op, iss_rd, iss_rs1, iss_rs2, iss_imm},
          ent(2'd0, 3'd0, 5'd3, 5'd2, 5'd0, 12'd0));
    repeat (10) @(posedge clk1);
    #1;
    check("t2_pc_frozen", 32'(pc_out), 32'(p));
    check("t2_none_issued", 32'(n_issued), 32'd0);
    rs_ready = 3'b111;
    wait_halted("t2_halted");
    check("t2_issued", 32'(n_issued), 32'd7);

    // 3: blocked DIV head holds back a ready ADD
    clear_prog();
    put_rr(0, 3'd4, 5'd2, 5'd3, 5'd4);
    put_rr(1, 3'd1, 5'd1, 5'd2, 5'd3);
    rs_ready = 3'b011;
    reset_dut();
    repeat (15) @(posedge clk1);
    #1;
    check("t3_head_valid", 32'(iss_valid), 32'd1);
    check("t3_head_div", 32'(iss_op), 32'd4);
    check("t3_none_issued", 32'(n_issued), 32'd0);
    rs_ready = 3'b111;
    wait_halted("t3_halted");
    check("t3_issued", 32'(n_issued), 32'd2);

    // 4: HALT opcode at PC 2, younger words discarded
    clear_prog();
    put_lw(0, 5'd5, 5'd6, 12'hA5C);
    put_rr(1, 3'd1, 5'd7, 5'd8, 5'd9);
    prog[2] = 32'h0000_0014;
    prog[3] = rr_word(3'd3, 5'd10, 5'd11, 5'd12);
    prog[4] = rr_word(3'd1, 5'd13, 5'd14, 5'd15);
    rs_ready = 3'b111;
    reset_dut();
    wait_halted("t4_halted");
    p = pc_out;
    repeat (6) @(posedge clk1);
    #1;
    check("t4_pc_frozen", 32'(pc_out), 32'(p));
    check("t4_issued", 32'(n_issued), 32'd2);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);
    check("t4_illegal", 32'(illegal), 32'd0);

    // 5: undecodable word dropped, sticky illegal
    clear_prog();
    put_rr(0, 3'd1, 5'd1, 5'd2, 5'd3);
    prog[1] = 32'hFFFF_FFFF;
    put_rr(2, 3'd2, 5'd4, 5'd5, 5'd6);
    rs_ready = 3'b111;
    reset_dut();
    wait_halted("t5_halted");
    check("t5_illegal", 32'(illegal), 32'd1);
    check("t5_issued", 32'(n_issued), 32'd2);

    // 6: reset mid-stream with three entries queued
    clear_prog();
    prog1();
    rs_ready = 3'b000;
    reset_dut();
    repeat (5) @(posedge clk1);
    #1;
    check("t6_pre_valid", 32'(iss_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk1);
    #1;
    check("t6_rst_valid", 32'(iss_valid), 32'd0);
    check("t6_rst_pc", 32'(pc_out), 32'd0);
    clear_prog();
    prog1();
    rst = 1'b0;
    @(posedge clk1);
    #1;
    check("t6_pc_cycle1", 32'(pc_out), 32'd0);
    @(posedge clk1);
    #1;
    check("t6_pc_cycle2", 32'(pc_out), 32'd1);
    rs_ready = 3'b111;
    wait_halted("t6_halted");
    check("t6_issued", 32'(n_issued), 32'd7);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
